// File: rtl/muladd_pkg.sv
// Shared types and constant helpers for the muladd_acc_pipe DSP slice.
// Saturation limits are built at 64 bits and sliced by each user.
package muladd_pkg;

    typedef enum logic {
        ADD_EXT_C,
        ADD_ACC_Q
    } addend_e;

    typedef struct packed {
        logic [63:0] max;
        logic [63:0] min;
    } sat_lim_t;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    function automatic bit widths_ok(input int a_w, input int b_w, input int acc_w);
        return (acc_w >= prod_width(a_w, b_w)) && (acc_w < 64);
    endfunction

    function automatic sat_lim_t sat_limits(input int width, input bit is_signed);
        sat_lim_t lim;
        if (is_signed) begin
            lim.max = (64'd1 << (width - 1)) - 64'd1;
            lim.min = ~64'd0 << (width - 1);
        end else begin
            lim.max = (64'd1 << width) - 64'd1;
            lim.min = 64'd0;
        end
        return lim;
    endfunction

endpackage

// File: rtl/muladd_acc_pipe_if.sv
// Operand/result bundle of the muladd_acc_pipe slice.
// The master drives operand beats; the slave returns Q and flags.
interface muladd_acc_pipe_if #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 20
);
    logic                 in_valid;
    logic [A_WIDTH-1:0]   A;
    logic [B_WIDTH-1:0]   B;
    logic [ACC_WIDTH-1:0] C;
    logic                 acc_en;
    logic                 acc_load;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] Q;
    logic                 ovf;

    modport master (
        output in_valid, A, B, C, acc_en, acc_load,
        input  out_valid, Q, ovf
    );

    modport slave (
        input  in_valid, A, B, C, acc_en, acc_load,
        output out_valid, Q, ovf
    );
endinterface

// File: rtl/muladd_sat_add.sv
// Combinational W+1 bit adder with overflow detect and wrap/clamp select.
// On signed overflow both operands share a sign, so the product sign picks the limit.
module muladd_sat_add
    import muladd_pkg::*;
#(
    parameter int W        = 20,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 0
) (
    input  logic [W-1:0] prod,
    input  logic [W-1:0] addend,
    output logic [W-1:0] result,
    output logic         ovf
);
    localparam sat_lim_t LIM = sat_limits(W, SIGNED != 0);

    logic [W:0] sum;

    always_comb begin
        sum    = {1'b0, prod} + {1'b0, addend};
        result = sum[W-1:0];
        if (SIGNED != 0) begin
            ovf = (prod[W-1] == addend[W-1]) && (sum[W-1] != prod[W-1]);
        end else begin
            ovf = sum[W];
        end
        if ((SATURATE != 0) && ovf) begin
            if ((SIGNED != 0) && prod[W-1]) begin
                result = LIM.min[W-1:0];
            end else begin
                result = LIM.max[W-1:0];
            end
        end
    end
endmodule

// File: rtl/muladd_acc_pipe.sv
// Parametrised multiply-add / MAC slice: Q = A*B + (C or Q).
// Optional input register; accumulator and sticky ovf live in the output stage.
module muladd_acc_pipe
    import muladd_pkg::*;
#(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int ACC_WIDTH = 20,
    parameter int SIGNED    = 1,
    parameter int IN_REG    = 0,
    parameter int SATURATE  = 0
) (
    input  logic             CLK,
    input  logic             clr,
    muladd_acc_pipe_if.slave bus
);
    localparam int PW = prod_width(A_WIDTH, B_WIDTH);

    if (!widths_ok(A_WIDTH, B_WIDTH, ACC_WIDTH)) begin : g_bad_widths
        $error("muladd_acc_pipe: ACC_WIDTH must cover A_WIDTH+B_WIDTH");
    end

    typedef struct packed {
        logic                 vld;
        logic                 acc_en;
        logic                 acc_load;
        logic [A_WIDTH-1:0]   a;
        logic [B_WIDTH-1:0]   b;
        logic [ACC_WIDTH-1:0] c;
    } beat_t;

    beat_t in_beat;
    beat_t ex;

    always_comb begin
        in_beat.vld      = bus.in_valid;
        in_beat.acc_en   = bus.acc_en;
        in_beat.acc_load = bus.acc_load;
        in_beat.a        = bus.A;
        in_beat.b        = bus.B;
        in_beat.c        = bus.C;
    end

    if (IN_REG != 0) begin : g_in_reg
        beat_t st_d;
        beat_t st_q;

        always_comb st_d = in_beat;

        always_ff @(posedge CLK) begin
            if (clr) begin
                st_q <= '0;
            end else begin
                st_q <= st_d;
            end
        end

        assign ex = st_q;
    end else begin : g_no_reg
        assign ex = in_beat;
    end

    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] addend;
    logic [ACC_WIDTH-1:0] sum_res;
    logic                 sum_ovf;
    addend_e              sel;

    logic [ACC_WIDTH-1:0] q_d, q_q;
    logic                 ovf_d, ovf_q;
    logic                 vld_d, vld_q;

    // Operands are extended to PW so the truncated product is exact either way.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext    = {{B_WIDTH{ex.a[A_WIDTH-1]}}, ex.a};
            b_ext    = {{A_WIDTH{ex.b[B_WIDTH-1]}}, ex.b};
            prod     = a_ext * b_ext;
            prod_ext = ACC_WIDTH'($signed(prod));
        end else begin
            a_ext    = {{B_WIDTH{1'b0}}, ex.a};
            b_ext    = {{A_WIDTH{1'b0}}, ex.b};
            prod     = a_ext * b_ext;
            prod_ext = ACC_WIDTH'(prod);
        end
        sel = (ex.acc_en && !ex.acc_load) ? ADD_ACC_Q : ADD_EXT_C;
        unique case (sel)
            ADD_ACC_Q: addend = q_q;
            ADD_EXT_C: addend = ex.c;
        endcase
    end

    muladd_sat_add #(
        .W        (ACC_WIDTH),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_add (
        .prod   (prod_ext),
        .addend (addend),
        .result (sum_res),
        .ovf    (sum_ovf)
    );

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q;
        vld_d = ex.vld;
        if (ex.vld) begin
            q_d = sum_res;
            if (sum_ovf) begin
                ovf_d = 1'b1;
            end else if (!ex.acc_en || ex.acc_load) begin
                ovf_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            vld_q <= vld_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_muladd_acc_pipe.sv
// Scoreboard bench for muladd_acc_pipe across five parameter sets.
// Expected beats are queued at drive time and popped when out_valid rises.
module tb_muladd_acc_pipe;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit clr_pe   = 1'b0;

    always @(posedge clk) begin
        cyc++;
        clr_pe = clr;
    end

    muladd_acc_pipe_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(20)) i0 ();
    muladd_acc_pipe_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(20)) i1 ();
    muladd_acc_pipe_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(20)) i2 ();
    muladd_acc_pipe_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16)) i3 ();
    muladd_acc_pipe_if #(.A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(16)) i4 ();

    muladd_acc_pipe u0 (.CLK(clk), .clr(clr), .bus(i0));
    muladd_acc_pipe #(.IN_REG(1)) u1 (.CLK(clk), .clr(clr), .bus(i1));
    muladd_acc_pipe #(.SATURATE(1)) u2 (.CLK(clk), .clr(clr), .bus(i2));
    muladd_acc_pipe #(
        .ACC_WIDTH(16), .SIGNED(0), .SATURATE(0)
    ) u3 (.CLK(clk), .clr(clr), .bus(i3));
    muladd_acc_pipe #(
        .ACC_WIDTH(16), .SIGNED(0), .SATURATE(1)
    ) u4 (.CLK(clk), .clr(clr), .bus(i4));

    typedef struct {
        int q;
        bit f;
        int due;
    } exp_t;

    exp_t        sb[5][$];
    logic [19:0] lastq[5];
    bit          lastf[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input int q, input bit f, input int lat);
        exp_t e;
        e.q   = q;
        e.f   = f;
        e.due = cyc + lat;
        sb[id].push_back(e);
    endtask

    task automatic mon(input int id, input logic v, input logic [19:0] q, input logic f);
        exp_t e;
        if (clr_pe) begin
            chk($sformatf("rst_valid%0d", id), 32'(v), 0);
            chk($sformatf("rst_q%0d", id), 32'(q), 0);
            chk($sformatf("rst_ovf%0d", id), 32'(f), 0);
            lastq[id] = '0;
            lastf[id] = 1'b0;
        end else if (v === 1'b1) begin
            if (sb[id].size() == 0) begin
                chk($sformatf("unexpected_valid%0d", id), 32'(v), 0);
            end else begin
                e = sb[id].pop_front();
                chk($sformatf("latency%0d", id), cyc, e.due);
                chk($sformatf("q%0d", id), 32'(q), e.q & 32'hFFFFF);
                chk($sformatf("ovf%0d", id), 32'(f), 32'(e.f));
                lastq[id] = q;
                lastf[id] = f;
            end
        end else begin
            chk($sformatf("hold_q%0d", id), 32'(q), 32'(lastq[id]));
            chk($sformatf("hold_ovf%0d", id), 32'(f), 32'(lastf[id]));
            if (sb[id].size() != 0 && sb[id][0].due <= cyc) begin
                chk($sformatf("missing_valid%0d", id), 32'(v), 1);
                void'(sb[id].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, i0.out_valid, i0.Q, i0.ovf);
        mon(1, i1.out_valid, i1.Q, i1.ovf);
        mon(2, i2.out_valid, i2.Q, i2.ovf);
        mon(3, i3.out_valid, {4'b0, i3.Q}, i3.ovf);
        mon(4, i4.out_valid, {4'b0, i4.Q}, i4.ovf);
    end

    task automatic s0(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [19:0] c, input bit en, input bit ld);
        i0.in_valid = v; i0.A = a; i0.B = b; i0.C = c;
        i0.acc_en = en; i0.acc_load = ld;
    endtask

    task automatic s1(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [19:0] c, input bit en, input bit ld);
        i1.in_valid = v; i1.A = a; i1.B = b; i1.C = c;
        i1.acc_en = en; i1.acc_load = ld;
    endtask

    task automatic s2(input bit v, input logic [7:0] a, input logic [7:0] b,
                      input logic [19:0] c, input bit en, input bit ld);
        i2.in_valid = v; i2.A = a; i2.B = b; i2.C = c;
        i2.acc_en = en; i2.acc_load = ld;
    endtask

    task automatic s34(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] c);
        i3.in_valid = v; i3.A = a; i3.B = b; i3.C = c;
        i3.acc_en = 1'b0; i3.acc_load = 1'b0;
        i4.in_valid = v; i4.A = a; i4.B = b; i4.C = c;
        i4.acc_en = 1'b0; i4.acc_load = 1'b0;
    endtask

    task automatic quiet();
        i0.in_valid = 1'b0;
        i1.in_valid = 1'b0;
        i2.in_valid = 1'b0;
        i3.in_valid = 1'b0;
        i4.in_valid = 1'b0;
    endtask

    int ta[6] = '{10, 10, -5, -1, -128, -128};
    int tb[6] = '{10, -5, -5, -1, -128, 127};
    int te[6] = '{100, -50, 25, 1, 16384, -16256};

    initial begin
        clr = 1'b1;
        s0(0, 0, 0, 0, 0, 0);
        s1(0, 0, 0, 0, 0, 0);
        s2(0, 0, 0, 0, 0, 0);
        s34(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        clr = 1'b0;

        // signed products with C=0
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s0(1, 8'(ta[i]), 8'(tb[i]), 20'd0, 0, 0);
            push(0, te[i], 1'b0, 1);
        end
        @(negedge clk);
        quiet();
        repeat (3) @(negedge clk);

        // registered input stage, accumulate with a bubble
        s1(1, 8'd3, 8'd4, 20'd7, 1, 1);
        push(1, 19, 1'b0, 2);
        @(negedge clk);
        s1(1, 8'd3, 8'd4, 20'd0, 1, 0);
        push(1, 31, 1'b0, 2);
        @(negedge clk);
        quiet();
        @(negedge clk);
        s1(1, 8'd3, 8'd4, 20'd0, 1, 0);
        push(1, 43, 1'b0, 2);
        @(negedge clk);
        quiet();
        repeat (4) @(negedge clk);

        // 32-beat accumulate to overflow: u2 saturates, u0 wraps
        for (int k = 0; k < 32; k++) begin
            s0(1, 8'h80, 8'h80, 20'd0, 1, k == 0);
            s2(1, 8'h80, 8'h80, 20'd0, 1, k == 0);
            if (k < 31) begin
                push(0, 16384 * (k + 1), 1'b0, 1);
                push(2, 16384 * (k + 1), 1'b0, 1);
            end else begin
                push(0, -524288, 1'b1, 1);
                push(2, 524287, 1'b1, 1);
            end
            @(negedge clk);
        end
        s0(1, 8'd1, 8'd1, 20'd0, 1, 0);
        push(0, -524287, 1'b1, 1);
        s2(1, 8'h80, 8'h80, 20'd0, 1, 0);
        push(2, 524287, 1'b1, 1);
        @(negedge clk);
        s0(1, 8'd1, 8'd1, 20'd0, 1, 1);
        push(0, 1, 1'b0, 1);
        s2(1, 8'd1, 8'd1, 20'd5, 0, 0);
        push(2, 6, 1'b0, 1);
        @(negedge clk);
        quiet();
        repeat (3) @(negedge clk);

        // unsigned 16-bit: carry-out wraps or clamps
        s34(1, 8'd255, 8'd255, 16'd0);
        push(3, 65025, 1'b0, 1);
        push(4, 65025, 1'b0, 1);
        @(negedge clk);
        s34(1, 8'd255, 8'd255, 16'd600);
        push(3, 89, 1'b1, 1);
        push(4, 65535, 1'b1, 1);
        @(negedge clk);
        quiet();
        repeat (4) @(negedge clk);

        // clr with one beat in flight and one arriving
        s1(1, 8'd5, 8'd5, 20'd0, 1, 0);
        @(negedge clk);
        s1(1, 8'd6, 8'd6, 20'd0, 0, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        quiet();
        chk("clr_q", 32'(i1.Q), 0);
        chk("clr_ovf", 32'(i1.ovf), 0);
        repeat (3) @(negedge clk);
        s1(1, 8'd2, 8'd3, 20'd0, 1, 0);
        push(1, 6, 1'b0, 2);
        @(negedge clk);
        quiet();
        repeat (4) @(negedge clk);

        for (int id = 0; id < 5; id++) begin
            chk($sformatf("drain%0d", id), sb[id].size(), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/muladd_acc_pipe.md
Name: muladd_acc_pipe

Overview:
- Parametrised successor to the fixed 8x8 / 20-bit MULADDA primitive.
- Computes Q = A*B + C, or accumulates Q = A*B + Q_prev.
- Configurable operand and accumulator widths, signedness, optional input register stage, wrap or saturate on overflow, valid-tagged pipeline and a sticky overflow flag.
- Sits in the fabric DSP tile as the mapping target for multiply/MAC inference.

Parameters:
- A_WIDTH, 8, multiplicand width.
- B_WIDTH, 8, multiplier width.
- ACC_WIDTH, 20, addend/accumulator/result width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise).
- SIGNED, 1, 1 = two's-complement operands and result; 0 = unsigned.
- IN_REG, 0, 1 = register A, B, C, mode bits and in_valid before the multiplier (adds one cycle).
- SATURATE, 0, 1 = clamp result on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- CLK  in  1  clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- A  in  A_WIDTH  multiplicand.
- B  in  B_WIDTH  multiplier.
- C  in  ACC_WIDTH  external addend.
- acc_en  in  1  1 = add to previous Q; 0 = add C.
- acc_load  in  1  with acc_en=1: restart the accumulation from C (Q = A*B + C) and clear ovf.
- out_valid  out  1  Q updated this cycle.
- Q  out  ACC_WIDTH  registered result.
- ovf  out  1  sticky overflow flag.

Behaviour:
- Reset: when clr=1 at a rising edge, Q=0, out_valid=0, ovf=0 and all input-stage registers (including the valid bit) are 0. In-flight beats are dropped.
- clr has priority over in_valid in the same cycle; that beat is discarded.
- Latency from in_valid to out_valid is 1+IN_REG cycles. Throughput is one beat per cycle, with no backpressure.
- acc_en, acc_load, A, B and C travel together through the input stage. Mode bits are sampled with their beat, not at the output stage.
- Product: P = A*B at width A_WIDTH+B_WIDTH, then sign-extended (SIGNED=1) or zero-extended (SIGNED=0) to ACC_WIDTH.
- Addend select:
  - acc_en=0: C.
  - acc_en=1, acc_load=1: C.
  - acc_en=1, acc_load=0: current Q register.
- Sum is formed at ACC_WIDTH+1 bits.
- Overflow detection:
  - SIGNED=1: overflow when both operands have equal sign and the result sign differs.
  - SIGNED=0: overflow on carry out.
- On overflow:
  - SATURATE=1: Q = max (signed 2^(ACC_WIDTH-1)-1, unsigned all-ones) or signed min, chosen by the sign of the product.
  - SATURATE=0: Q = low ACC_WIDTH bits of the sum.
- ovf:
  - Set on any overflowing valid beat.
  - Held until clr, or until a valid beat with acc_en=0 or acc_load=1 that does not itself overflow.
  - If the clearing beat overflows, ovf stays 1.
- Bubble (valid bit 0 at the output stage): Q and ovf hold, and out_valid=0 on the next cycle.
- Back-to-back accumulate with IN_REG=1 uses the Q from the immediately preceding beat. No hazard exists because the accumulator lives in the output stage only.

Decomposition:
- Package muladd_pkg holds:
  - function sat_limits(width, signed) returning the max/min constants;
  - localparam PROD_WIDTH = A_WIDTH+B_WIDTH (re-derived per instance);
  - an elaboration check helper.
- One natural sub-module, muladd_sat_add: combinational (ACC_WIDTH+1)-bit add with overflow detect and clamp/wrap select, parametrised by SIGNED and SATURATE. The output register and valid pipeline stay in the top module.

Test Plan:
1. Defaults, acc_en=0, C=0, one beat each:
   - (10,10) -> Q=100
   - (10,-5) -> -50
   - (-5,-5) -> 25
   - (-1,-1) -> 1
   - (-128,-128) -> 16384
   - (-128,127) -> -16256
   - out_valid pulses exactly 1 cycle after each in_valid.
2. IN_REG=1, acc_en=1, acc_load=1 on the first beat with C=7, then three beats of (3,4) -> Q sequence 19, 31, 43. Latency is 2. Insert an in_valid=0 bubble -> Q holds at 31 and out_valid=0.
3. SATURATE=1, acc_en=1, 32 beats of (-128,-128) from acc_load with C=0 -> Q=507904 after 31 beats, then 524287 with ovf=1. A further beat keeps 524287 and ovf=1.
4. Same as 3 with SATURATE=0 -> 32nd beat gives Q=-524288 (wrap), ovf=1. A following acc_load beat with C=0 and (1,1) -> Q=1, ovf=0.
5. SIGNED=0, A_WIDTH=B_WIDTH=8, ACC_WIDTH=16, acc_en=0, C=0 -> (255,255) gives 65025 with no ovf. Then C=600 -> 65625 mod 65536 = 89 with ovf=1; with SATURATE=1 the result is 65535 instead.
6. Assert clr in the same cycle as a valid beat while another beat is in flight (IN_REG=1) -> out_valid stays 0 for both beats, Q=0, ovf=0. The next valid beat behaves as after cold reset.
